vga_timing: RTL and testbench

Raster timing generator for the 640x480 VGA output. It runs in the pixel clock domain driven by the PLL's 25.125 MHz output (800 x 525 total, ~59.82 Hz frame). It produces registered, glitch-free sync pulses, an active-video flag and pixel coordinates for the pixel pipeline. It also produces line-start and frame-start strobes for frame-buffer address reset.

---
 rtl/vga_timing.sv | 107 ++++++++++
 tb/tb_vga_timing.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters with a registered decode of
// sync pulses, active-video flag, pixel coordinates and line/frame strobes.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clock_in,
    input  logic       resetn,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CMP_W   = CNT_W + 1;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Decode bounds are one bit wider so an end bound of 1024 still compares correctly.
    localparam logic [CMP_W-1:0] H_ACT_END = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] HS_BEG    = CMP_W'(H_ACTIVE + H_FRONT);
    localparam logic [CMP_W-1:0] HS_END    = CMP_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CMP_W-1:0] V_ACT_END = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] VS_BEG    = CMP_W'(V_ACTIVE + V_FRONT);
    localparam logic [CMP_W-1:0] VS_END    = CMP_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_next_c;
    logic [CNT_W-1:0] v_next_c;
    logic [CMP_W-1:0] h_ext_c;
    logic [CMP_W-1:0] v_ext_c;
    logic             active_c;
    logic             hsync_c;
    logic             vsync_c;
    logic             line_start_c;
    logic             frame_start_c;

    // Counter advance and output decode from the current counter values
    always_comb begin
        h_next_c      = h_cnt + CNT_W'(1);
        v_next_c      = v_cnt;
        h_ext_c       = {1'b0, h_cnt};
        v_ext_c       = {1'b0, v_cnt};
        active_c      = 1'b0;
        hsync_c       = ~SYNC_POL;
        vsync_c       = ~SYNC_POL;
        line_start_c  = 1'b0;
        frame_start_c = 1'b0;

        if (h_cnt == H_LAST) begin
            h_next_c = '0;
            v_next_c = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end

        active_c = (h_ext_c < H_ACT_END) && (v_ext_c < V_ACT_END);
        if ((h_ext_c >= HS_BEG) && (h_ext_c < HS_END)) begin
            hsync_c = SYNC_POL;
        end
        if ((v_ext_c >= VS_BEG) && (v_ext_c < VS_END)) begin
            vsync_c = SYNC_POL;
        end
        line_start_c  = (h_cnt == '0);
        frame_start_c = (h_cnt == '0) && (v_cnt == '0);
    end

    // Counters and output flops share one enable so everything freezes together
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            h_cnt       <= h_next_c;
            v_cnt       <= v_next_c;
            x           <= h_cnt;
            y           <= v_cnt;
            active      <= active_c;
            hsync       <= hsync_c;
            vsync       <= vsync_c;
            line_start  <= line_start_c;
            frame_start <= frame_start_c;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default raster for line timing, a short-frame
// raster for frame-level behaviour, and a tiny positive-polarity raster.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, hs_a, vs_a, act_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       rst_v, en_v, hs_v, vs_v, act_v, ls_v, fs_v;
    logic [9:0] x_v, y_v;
    logic       rst_s, en_s, hs_s, vs_s, act_s, ls_s, fs_s;
    logic [9:0] x_s, y_s;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Default 640x480 raster
    vga_timing dut_a (
        .clock_in(clk), .resetn(rst_a), .enable(en_a),
        .hsync(hs_a), .vsync(vs_a), .active(act_a),
        .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    // Default horizontal timing, short vertical: 12 active, sync lines 14..15, 19 lines total
    vga_timing #(
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_v (
        .clock_in(clk), .resetn(rst_v), .enable(en_v),
        .hsync(hs_v), .vsync(vs_v), .active(act_v),
        .x(x_v), .y(y_v), .line_start(ls_v), .frame_start(fs_v)
    );

    // Tiny raster, active-high syncs: 14 x 7
    vga_timing #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clock_in(clk), .resetn(rst_s), .enable(en_s),
        .hsync(hs_s), .vsync(vs_s), .active(act_s),
        .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
    );

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (x_a !== 10'd0)  $display("FAIL reset_x: got %0d want 0", x_a); else pass_cnt++;
        total_cnt++; if (y_a !== 10'd0)  $display("FAIL reset_y: got %0d want 0", y_a); else pass_cnt++;
        total_cnt++; if (act_a !== 1'b0) $display("FAIL reset_active: got %b want 0", act_a); else pass_cnt++;
        total_cnt++; if (ls_a !== 1'b0)  $display("FAIL reset_line_start: got %b want 0", ls_a); else pass_cnt++;
        total_cnt++; if (fs_a !== 1'b0)  $display("FAIL reset_frame_start: got %b want 0", fs_a); else pass_cnt++;
        total_cnt++; if (hs_a !== 1'b1)  $display("FAIL reset_hsync: got %b want 1", hs_a); else pass_cnt++;
        total_cnt++; if (vs_a !== 1'b1)  $display("FAIL reset_vsync: got %b want 1", vs_a); else pass_cnt++;
        total_cnt++; if (hs_s !== 1'b0)  $display("FAIL reset_hsync_pol1: got %b want 0", hs_s); else pass_cnt++;
        total_cnt++; if (vs_s !== 1'b0)  $display("FAIL reset_vsync_pol1: got %b want 0", vs_s); else pass_cnt++;
    endtask

    task automatic test_first_line();
        int x_err, act_err, hs_err, ls_err, hs_low, hs_first;
        logic act_639, act_640;
        x_err = 0; act_err = 0; hs_err = 0; ls_err = 0; hs_low = 0; hs_first = -1;
        act_639 = 1'b0; act_640 = 1'b1;
        rst_a = 1'b1;
        en_a  = 1'b1;
        @(negedge clk);
        total_cnt++; if (x_a !== 10'd0 || y_a !== 10'd0)
            $display("FAIL first_xy: got (%0d,%0d) want (0,0)", x_a, y_a); else pass_cnt++;
        total_cnt++; if ({act_a, ls_a, fs_a} !== 3'b111)
            $display("FAIL first_flags: got act/ls/fs=%b%b%b want 111", act_a, ls_a, fs_a); else pass_cnt++;
        total_cnt++; if ({hs_a, vs_a} !== 2'b11)
            $display("FAIL first_syncs: got hs/vs=%b%b want 11", hs_a, vs_a); else pass_cnt++;
        for (int c = 1; c < 800; c++) begin
            @(negedge clk);
            if (x_a !== 10'(c) || y_a !== 10'd0) x_err++;
            if (act_a !== (c < 640)) act_err++;
            if (hs_a !== !(c >= 656 && c < 752)) hs_err++;
            if (ls_a !== 1'b0 || fs_a !== 1'b0) ls_err++;
            if (hs_a === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            if (c == 639) act_639 = act_a;
            if (c == 640) act_640 = act_a;
        end
        total_cnt++; if (x_err != 0)  $display("FAIL line_xy_seq: got %0d bad samples want 0", x_err); else pass_cnt++;
        total_cnt++; if (act_639 !== 1'b1) $display("FAIL active_x639: got %b want 1", act_639); else pass_cnt++;
        total_cnt++; if (act_640 !== 1'b0) $display("FAIL active_x640: got %b want 0", act_640); else pass_cnt++;
        total_cnt++; if (act_err != 0) $display("FAIL line_active: got %0d bad samples want 0", act_err); else pass_cnt++;
        total_cnt++; if (hs_err != 0)  $display("FAIL line_hsync: got %0d bad samples want 0", hs_err); else pass_cnt++;
        total_cnt++; if (hs_low != 96) $display("FAIL hsync_width: got %0d want 96", hs_low); else pass_cnt++;
        total_cnt++; if (hs_first != 656) $display("FAIL hsync_start: got %0d want 656", hs_first); else pass_cnt++;
        total_cnt++; if (ls_err != 0)  $display("FAIL line_strobes: got %0d stray strobes want 0", ls_err); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (x_a !== 10'd0 || y_a !== 10'd1)
            $display("FAIL second_line_xy: got (%0d,%0d) want (0,1)", x_a, y_a); else pass_cnt++;
        total_cnt++; if ({ls_a, fs_a} !== 2'b10)
            $display("FAIL second_line_strobes: got ls/fs=%b%b want 10", ls_a, fs_a); else pass_cnt++;
    endtask

    task automatic test_enable_hold();
        int hold_err, n;
        logic found;
        found = 1'b0;
        hold_err = 0;
        for (n = 0; n < 5000 && !found; n++) begin
            @(negedge clk);
            if (x_a === 10'd100 && y_a === 10'd5) found = 1'b1;
        end
        total_cnt++; if (!found) $display("FAIL hold_reach: got timeout want (100,5)"); else pass_cnt++;
        en_a = 1'b0;
        repeat (37) begin
            @(negedge clk);
            if (x_a !== 10'd100 || y_a !== 10'd5 || act_a !== 1'b1 ||
                hs_a !== 1'b1 || vs_a !== 1'b1 || ls_a !== 1'b0) hold_err++;
        end
        total_cnt++; if (hold_err != 0) $display("FAIL hold_outputs: got %0d bad samples want 0", hold_err); else pass_cnt++;
        en_a = 1'b1;
        @(negedge clk);
        total_cnt++; if (x_a !== 10'd101 || y_a !== 10'd5)
            $display("FAIL hold_resume: got (%0d,%0d) want (101,5)", x_a, y_a); else pass_cnt++;
        // A strobe caught by a stall stays high until the next enabled edge
        found = 1'b0;
        for (n = 0; n < 1000 && !found; n++) begin
            @(negedge clk);
            if (ls_a === 1'b1) found = 1'b1;
        end
        en_a = 1'b0;
        hold_err = 0;
        repeat (3) begin
            @(negedge clk);
            if (ls_a !== 1'b1 || x_a !== 10'd0 || y_a !== 10'd6) hold_err++;
        end
        total_cnt++; if (!found || hold_err != 0)
            $display("FAIL strobe_hold: got found=%b bad=%0d want found=1 bad=0", found, hold_err); else pass_cnt++;
        en_a = 1'b1;
        @(negedge clk);
        total_cnt++; if (ls_a !== 1'b0 || x_a !== 10'd1)
            $display("FAIL strobe_release: got ls=%b x=%0d want ls=0 x=1", ls_a, x_a); else pass_cnt++;
    endtask

    // Caller leaves dut_v sampled on its frame_start cycle; counts cycles to the next one
    task automatic run_frame(input string tag, input logic stall, output int len);
        int act_err, vs_err, vs_low;
        int vs_fx, vs_fy;
        int last_x, last_y;
        logic stalled, vs_ls;
        act_err = 0; vs_err = 0; vs_low = 0; vs_fx = -1; vs_fy = -1;
        last_x = -1; last_y = -1; stalled = 1'b0; vs_ls = 1'b0;
        len = 0;
        while (len < 20000) begin
            last_x = int'(x_v);
            last_y = int'(y_v);
            @(negedge clk);
            len++;
            if (fs_v === 1'b1) break;
            if (act_v !== (x_v < 10'd640 && y_v < 10'd12)) act_err++;
            if (vs_v !== !(y_v == 10'd14 || y_v == 10'd15)) vs_err++;
            if (vs_v === 1'b0) begin
                vs_low++;
                if (vs_fx < 0) begin
                    vs_fx = int'(x_v); vs_fy = int'(y_v); vs_ls = ls_v;
                end
            end
            if (stall && !stalled && x_v === 10'd100 && y_v === 10'd5) begin
                stalled = 1'b1;
                en_v = 1'b0;
                repeat (37) begin
                    @(negedge clk);
                    len++;
                end
                en_v = 1'b1;
            end
        end
        total_cnt++; if (act_err != 0) $display("FAIL %s_active: got %0d bad samples want 0", tag, act_err); else pass_cnt++;
        total_cnt++; if (vs_err != 0)  $display("FAIL %s_vsync: got %0d bad samples want 0", tag, vs_err); else pass_cnt++;
        total_cnt++; if (vs_low != 1600) $display("FAIL %s_vsync_width: got %0d want 1600", tag, vs_low); else pass_cnt++;
        total_cnt++; if (vs_fx != 0 || vs_fy != 14 || vs_ls !== 1'b1)
            $display("FAIL %s_vsync_start: got (%0d,%0d) ls=%b want (0,14) ls=1", tag, vs_fx, vs_fy, vs_ls); else pass_cnt++;
        total_cnt++; if (last_x != 799 || last_y != 18)
            $display("FAIL %s_last: got (%0d,%0d) want (799,18)", tag, last_x, last_y); else pass_cnt++;
        total_cnt++; if (x_v !== 10'd0 || y_v !== 10'd0 || fs_v !== 1'b1)
            $display("FAIL %s_wrap: got (%0d,%0d) fs=%b want (0,0) fs=1", tag, x_v, y_v, fs_v); else pass_cnt++;
    endtask

    task automatic test_frame();
        int len;
        rst_v = 1'b1;
        en_v  = 1'b1;
        @(negedge clk);
        total_cnt++; if (fs_v !== 1'b1 || x_v !== 10'd0 || y_v !== 10'd0)
            $display("FAIL frame_first: got (%0d,%0d) fs=%b want (0,0) fs=1", x_v, y_v, fs_v); else pass_cnt++;
        run_frame("frame", 1'b0, len);
        total_cnt++; if (len != 15200) $display("FAIL frame_length: got %0d want 15200", len); else pass_cnt++;
    endtask

    task automatic test_frame_stall();
        int len;
        run_frame("stall", 1'b1, len);
        total_cnt++; if (len != 15237) $display("FAIL stall_length: got %0d want 15237", len); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int len;
        logic found;
        found = 1'b0;
        for (int n = 0; n < 20000 && !found; n++) begin
            @(negedge clk);
            if (x_v === 10'd700 && y_v === 10'd15) found = 1'b1;
        end
        total_cnt++; if (!found || hs_v !== 1'b0 || vs_v !== 1'b0)
            $display("FAIL areset_pre: got found=%b hs/vs=%b%b want found=1 hs/vs=00", found, hs_v, vs_v); else pass_cnt++;
        #2;
        rst_v = 1'b0;
        #1;
        total_cnt++; if (x_v !== 10'd0 || y_v !== 10'd0)
            $display("FAIL areset_xy: got (%0d,%0d) want (0,0)", x_v, y_v); else pass_cnt++;
        total_cnt++; if ({hs_v, vs_v, act_v, ls_v, fs_v} !== 5'b11000)
            $display("FAIL areset_flags: got hs/vs/act/ls/fs=%b%b%b%b%b want 11000", hs_v, vs_v, act_v, ls_v, fs_v); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (x_v !== 10'd0 || hs_v !== 1'b1 || act_v !== 1'b0)
            $display("FAIL areset_held: got x=%0d hs=%b act=%b want 0 1 0", x_v, hs_v, act_v); else pass_cnt++;
        rst_v = 1'b1;
        @(negedge clk);
        total_cnt++; if (fs_v !== 1'b1 || act_v !== 1'b1 || x_v !== 10'd0 || y_v !== 10'd0)
            $display("FAIL areset_restart: got (%0d,%0d) fs=%b act=%b want (0,0) fs=1 act=1", x_v, y_v, fs_v, act_v); else pass_cnt++;
        run_frame("rframe", 1'b0, len);
        total_cnt++; if (len != 15200) $display("FAIL rframe_length: got %0d want 15200", len); else pass_cnt++;
    endtask

    task automatic test_small_pol();
        int ex, ey, xy_err, hs_err, vs_err, act_err, fs_err, hs_hi;
        logic [9:0] x97, y97;
        xy_err = 0; hs_err = 0; vs_err = 0; act_err = 0; fs_err = 0; hs_hi = 0;
        x97 = '0; y97 = '0;
        rst_s = 1'b1;
        en_s  = 1'b1;
        for (int c = 0; c < 98; c++) begin
            @(negedge clk);
            ex = c % 14;
            ey = c / 14;
            if (x_s !== 10'(ex) || y_s !== 10'(ey)) xy_err++;
            if (hs_s !== (ex == 10 || ex == 11)) hs_err++;
            if (vs_s !== (ey == 5)) vs_err++;
            if (act_s !== (ex < 8 && ey < 4)) act_err++;
            if (fs_s !== (ex == 0 && ey == 0) || ls_s !== (ex == 0)) fs_err++;
            if (hs_s === 1'b1) hs_hi++;
            if (c == 97) begin x97 = x_s; y97 = y_s; end
        end
        total_cnt++; if (xy_err != 0)  $display("FAIL small_xy: got %0d bad samples want 0", xy_err); else pass_cnt++;
        total_cnt++; if (hs_err != 0)  $display("FAIL small_hsync: got %0d bad samples want 0", hs_err); else pass_cnt++;
        total_cnt++; if (hs_hi != 14)  $display("FAIL small_hsync_count: got %0d want 14", hs_hi); else pass_cnt++;
        total_cnt++; if (vs_err != 0)  $display("FAIL small_vsync: got %0d bad samples want 0", vs_err); else pass_cnt++;
        total_cnt++; if (act_err != 0) $display("FAIL small_active: got %0d bad samples want 0", act_err); else pass_cnt++;
        total_cnt++; if (fs_err != 0)  $display("FAIL small_strobes: got %0d bad samples want 0", fs_err); else pass_cnt++;
        total_cnt++; if (x97 !== 10'd13 || y97 !== 10'd6)
            $display("FAIL small_last: got (%0d,%0d) want (13,6)", x97, y97); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (x_s !== 10'd0 || y_s !== 10'd0 || fs_s !== 1'b1)
            $display("FAIL small_wrap: got (%0d,%0d) fs=%b want (0,0) fs=1", x_s, y_s, fs_s); else pass_cnt++;
    endtask

    initial begin
        rst_a = 1'b1; rst_v = 1'b1; rst_s = 1'b1;
        en_a  = 1'b0; en_v  = 1'b0; en_s  = 1'b0;
        #2;
        rst_a = 1'b0; rst_v = 1'b0; rst_s = 1'b0;
        test_reset();
        test_first_line();
        test_enable_hold();
        test_small_pol();
        test_frame();
        test_frame_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
